// File: rtl/sauria_cfg_axil_master.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sauria_cfg_axil_master : single-outstanding AXI4-Lite master for the SAURIA
//                          cfg slave port, with sticky hung-slave timeout flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module sauria_cfg_axil_master #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter logic [2:0]  AXI_PROT       = 3'b000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                i_system_clk,
  input  logic                i_system_rstn,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_wdata,
  input  logic [DATA_W/8-1:0] i_cmd_wstrb,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic                o_rsp_write,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic [1:0]          o_rsp_resp,
  output logic                o_timeout,
  output logic [ADDR_W-1:0]   o_cfg_axi_awaddr,
  output logic [2:0]          o_cfg_axi_awprot,
  output logic                o_cfg_axi_awvalid,
  input  logic                i_cfg_axi_awready,
  output logic [DATA_W-1:0]   o_cfg_axi_wdata,
  output logic [DATA_W/8-1:0] o_cfg_axi_wstrb,
  output logic                o_cfg_axi_wvalid,
  input  logic                i_cfg_axi_wready,
  input  logic [1:0]          i_cfg_axi_bresp,
  input  logic                i_cfg_axi_bvalid,
  output logic                o_cfg_axi_bready,
  output logic [ADDR_W-1:0]   o_cfg_axi_araddr,
  output logic [2:0]          o_cfg_axi_arprot,
  output logic                o_cfg_axi_arvalid,
  input  logic                i_cfg_axi_arready,
  input  logic [DATA_W-1:0]   i_cfg_axi_rdata,
  input  logic [1:0]          i_cfg_axi_rresp,
  input  logic                i_cfg_axi_rvalid,
  output logic                o_cfg_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic w_accept, w_busy, w_aw_hs, w_w_hs;

  assign w_accept = (state_q == S_IDLE) && i_cmd_valid;
  assign w_busy   = (state_q != S_IDLE) && (state_q != S_RSP);
  assign w_aw_hs  = o_cfg_axi_awvalid && i_cfg_axi_awready;
  assign w_w_hs   = o_cfg_axi_wvalid && i_cfg_axi_wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          addr_d    = i_cmd_addr;
          wdata_d   = i_cmd_wdata;
          wstrb_d   = i_cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = i_cmd_write ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave once both have been taken.
        if (w_aw_hs) aw_done_d = 1'b1;
        if (w_w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (i_cfg_axi_bvalid) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = i_cfg_axi_bresp;
          state_d     = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (i_cfg_axi_arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (i_cfg_axi_rvalid) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = i_cfg_axi_rdata;
          rsp_resp_d  = i_cfg_axi_rresp;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
    if (!i_system_rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Timeout only flags a hung slave; valids stay up so AXI ordering rules hold.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (w_accept) begin
        cnt_d     = '0;
        timeout_d = 1'b0;
      end else if (w_busy && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_MAX) timeout_d = 1'b1;
      end
    end

    always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
      if (!i_system_rstn) begin
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        timeout_q <= timeout_d;
      end
    end

    assign o_timeout = timeout_q;
  end else begin : g_no_timeout
    assign o_timeout = 1'b0;
  end

  // Held low while reset is asserted, not just once the state is IDLE.
  assign o_cmd_ready       = (state_q == S_IDLE) && i_system_rstn;
  assign o_rsp_valid       = (state_q == S_RSP);
  assign o_rsp_write       = rsp_write_q;
  assign o_rsp_rdata       = rsp_rdata_q;
  assign o_rsp_resp        = rsp_resp_q;
  assign o_cfg_axi_awaddr  = addr_q;
  assign o_cfg_axi_awprot  = AXI_PROT;
  assign o_cfg_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign o_cfg_axi_wdata   = wdata_q;
  assign o_cfg_axi_wstrb   = wstrb_q;
  assign o_cfg_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign o_cfg_axi_bready  = (state_q == S_WR_RESP);
  assign o_cfg_axi_araddr  = addr_q;
  assign o_cfg_axi_arprot  = AXI_PROT;
  assign o_cfg_axi_arvalid = (state_q == S_RD_REQ);
  assign o_cfg_axi_rready  = (state_q == S_RD_RESP);

endmodule
`default_nettype wire
